// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and types for the instruction-fetch stage.
//   XLEN_DEF / RESET_PC_DEF / PC_STEP_DEF / QDEPTH_DEF : default parameters
//   fetch_entry_t : one fetch-queue slot {pc, instr, filled} at default width
//   ptr_width()   : pointer width for a queue of a given depth
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam int unsigned QDEPTH_DEF   = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                filled;
  } fetch_entry_t;

  // Index width for a queue of 'depth' entries; at least one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch queue pairing issued PCs with returned words.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : drop every entry and rewind all pointers
//   alloc_i, alloc_pc_i  : reserve the next slot for a request to alloc_pc_i
//   fill_i, fill_instr_i : write the oldest unfilled slot with a returned word
//   pop_i                : release the head slot
//   cnt_o                : allocated slots
//   unfilled_o           : allocated slots still waiting for their word
//   head_filled_o, head_pc_o, head_instr_o : head slot contents
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned QDEPTH = QDEPTH_DEF,
  localparam int unsigned PW    = ptr_width(QDEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_instr_i,
  input  logic            pop_i,
  output logic [CW-1:0]   cnt_o,
  output logic [CW-1:0]   unfilled_o,
  output logic            head_filled_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } entry_t;

  entry_t        entry_q [QDEPTH];
  entry_t        entry_d [QDEPTH];
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] unfilled_q, unfilled_d;

  // Next-state for storage, pointers and occupancy counters.
  always_comb begin
    entry_d    = entry_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    cnt_d      = cnt_q;
    unfilled_d = unfilled_q;
    if (flush_i) begin
      // Stale pc/instr fields are left in place; only the filled flags matter.
      for (int i = 0; i < QDEPTH; i++) begin
        entry_d[i].filled = 1'b0;
      end
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      cnt_d      = '0;
      unfilled_d = '0;
    end else begin
      // Pop, alloc and fill always address distinct slots: alloc only
      // happens when not full, and fill targets an allocated unfilled slot.
      if (pop_i) begin
        entry_d[head_q].filled = 1'b0;
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      if (alloc_i) begin
        entry_d[alloc_q].pc     = alloc_pc_i;
        entry_d[alloc_q].instr  = '0;
        entry_d[alloc_q].filled = 1'b0;
        alloc_d = alloc_q + PW'(1);
      end else begin
        alloc_d = alloc_q;
      end
      if (fill_i) begin
        entry_d[fill_q].instr  = fill_instr_i;
        entry_d[fill_q].filled = 1'b1;
        fill_d = fill_q + PW'(1);
      end else begin
        fill_d = fill_q;
      end
      cnt_d      = cnt_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_d = unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entry_q[i] <= '0;
      end
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      cnt_q      <= '0;
      unfilled_q <= '0;
    end else begin
      entry_q    <= entry_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign unfilled_o    = unfilled_q;
  assign head_filled_o = entry_q[head_q].filled;
  assign head_pc_o     = entry_q[head_q].pc;
  assign head_instr_o  = entry_q[head_q].instr;

endmodule

// File: rtl/fetch_stage_q.sv
// fetch_stage_q: instruction-fetch stage with outstanding memory reads.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   br_taken_i, br_addr_i         : single-cycle redirect and its target
//   imem_req_valid_o/_ready_i     : read-request handshake, address imem_addr_o
//   imem_rsp_valid_i/_data_i      : in-order responses, no backpressure
//   if_valid_o/if_ready_i         : decode handshake carrying if_pc_o/if_instr_o
// The stage keeps issuing sequential PCs while queue slots plus responses
// still owed for flushed requests leave room. After a redirect those owed
// responses are counted in drop_q and swallowed as they return.
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(PC_STEP_DEF),
  parameter int unsigned     QDEPTH   = QDEPTH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_addr_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o
);

  localparam int unsigned PW = ptr_width(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_s, unfilled_s;
  logic [CW:0]     inflight_s;
  logic            req_fire_s, rsp_discard_s, fill_s, pop_s, head_filled_s;
  logic [XLEN-1:0] head_pc_s, head_instr_s;

  // Slots in use plus responses still owed for flushed requests bound issue.
  assign inflight_s       = {1'b0, cnt_s} + {1'b0, drop_q};
  assign imem_req_valid_o = !br_taken_i && (inflight_s < (CW+1)'(QDEPTH));
  assign imem_addr_o      = pc_q;
  assign req_fire_s       = imem_req_valid_o && imem_req_ready_i;

  assign rsp_discard_s = imem_rsp_valid_i && (drop_q != '0);
  assign fill_s        = imem_rsp_valid_i && (drop_q == '0) && !br_taken_i;

  assign if_valid_o = head_filled_s && !br_taken_i;
  assign if_pc_o    = head_pc_s;
  assign if_instr_o = head_instr_s;
  assign pop_s      = if_valid_o && if_ready_i;

  // Next PC and count of responses to discard.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (br_taken_i) begin
      pc_d   = br_addr_i;
      // Every unfilled slot becomes an owed response; any response arriving
      // now is discarded whichever group it belonged to.
      drop_d = drop_q + unfilled_s - CW'(imem_rsp_valid_i);
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      drop_d = drop_q - CW'(rsp_discard_s);
    end
  end

  // PC and discard-count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(
    .XLEN   (XLEN),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (br_taken_i),
    .alloc_i       (req_fire_s),
    .alloc_pc_i    (pc_q),
    .fill_i        (fill_s),
    .fill_instr_i  (imem_rsp_data_i),
    .pop_i         (pop_s),
    .cnt_o         (cnt_s),
    .unfilled_o    (unfilled_s),
    .head_filled_o (head_filled_s),
    .head_pc_o     (head_pc_s),
    .head_instr_o  (head_instr_s)
  );

endmodule

// File: tb/tb_fetch_stage_q.sv
// Bench for fetch_stage_q: directed table, hand sequences and random traffic
// checked against a list-based model of issued requests and owed responses.
module tb_fetch_stage_q;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken, req_ready, rsp_valid, if_ready;
  logic [31:0] br_addr, rsp_data;
  logic        req_valid, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;

  logic        w_br, w_req_ready, w_rsp_valid, w_if_ready;
  logic [31:0] w_br_addr, w_rsp_data;
  logic        w_req_valid, w_if_valid;
  logic [31:0] w_addr, w_if_pc, w_if_instr;

  always #5 clk = ~clk;

  fetch_stage_q dut (
    .clk_i(clk), .rst_ni(rst_n), .br_taken_i(br_taken), .br_addr_i(br_addr),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(imem_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .if_valid_o(if_valid), .if_ready_i(if_ready), .if_pc_o(if_pc), .if_instr_o(if_instr)
  );

  fetch_stage_q #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .br_taken_i(w_br), .br_addr_i(w_br_addr),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready), .imem_addr_o(w_addr),
    .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
    .if_valid_o(w_if_valid), .if_ready_i(w_if_ready), .if_pc_o(w_if_pc), .if_instr_o(w_if_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic        rr;
    logic        ir;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  int          n_err = 0;
  int          n_chk = 0;
  int          cyc, lat, epoch;
  logic [31:0] m_pc;
  logic [31:0] live_pc[$];
  bit          live_ret[$];
  mreq_t       mem_q[$];
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_instr;
  vec_t        tbl[10];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int l);
    m_pc = 32'h0;
    live_pc.delete();
    live_ret.delete();
    mem_q.delete();
    epoch = 0;
    lat = l;
    cyc = 0;
  endtask

  // Reset both DUTs and the model; returns shortly after a rising edge.
  task automatic do_reset(input int l);
    @(posedge clk);
    #2;
    rst_n = 1'b0; br_taken = 1'b0; br_addr = 32'h0; req_ready = 1'b0;
    if_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    model_reset(l);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs and memory response, compare, update model.
  task automatic step(input logic br, input logic [31:0] ba, input logic rr, input logic ir);
    int    stale;
    int    idx;
    bit    exp_rv, exp_iv, fire, pop, rsp;
    mreq_t m;
    @(negedge clk);
    br_taken = br; br_addr = ba; req_ready = rr; if_ready = ir;
    rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
    rsp_valid = rsp;
    if (rsp) rsp_data = memfn(mem_q[0].addr);
    else rsp_data = 32'h0;
    #1;
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    exp_rv = !br && ((live_pc.size() + stale) < QD);
    exp_iv = !br && (live_pc.size() > 0) && live_ret[0];
    s_rv = req_valid; s_addr = imem_addr; s_iv = if_valid; s_pc = if_pc; s_instr = if_instr;
    chk("imem_req_valid", {31'd0, s_rv}, {31'd0, exp_rv});
    if (exp_rv) chk("imem_addr", s_addr, m_pc);
    chk("if_valid", {31'd0, s_iv}, {31'd0, exp_iv});
    if (exp_iv) begin
      chk("if_pc", s_pc, live_pc[0]);
      chk("if_instr", s_instr, memfn(live_pc[0]));
    end
    fire = exp_rv && rr;
    pop  = exp_iv && ir;
    @(posedge clk);
    if (rsp) begin
      m = mem_q.pop_front();
      if (m.epoch == epoch && !br) begin
        idx = -1;
        foreach (live_ret[i]) if (idx < 0 && !live_ret[i]) idx = i;
        if (idx >= 0) live_ret[idx] = 1'b1;
      end
    end
    if (br) begin
      live_pc.delete();
      live_ret.delete();
      epoch++;
      m_pc = ba;
    end else begin
      if (pop) begin
        void'(live_pc.pop_front());
        void'(live_ret.pop_front());
      end
      if (fire) begin
        live_pc.push_back(m_pc);
        live_ret.push_back(1'b0);
        mem_q.push_back('{addr: m_pc, due: cyc + lat, epoch: epoch});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    bit          found;
    logic [31:0] rnd;
    rst_n = 1'b0; br_taken = 1'b0; br_addr = 32'h0; req_ready = 1'b0;
    if_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    w_br = 1'b0; w_br_addr = 32'h0; w_req_ready = 1'b0; w_rsp_valid = 1'b0;
    w_rsp_data = 32'h0; w_if_ready = 1'b0;

    //               rr    ir    rv    addr          iv    pc
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    // Reset state of both instances.
    do_reset(1);
    #1;
    chk("rst_req_valid", {31'd0, req_valid}, 32'd1);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    chk("rst_wrap_if_valid", {31'd0, w_if_valid}, 32'd0);
    chk("rst_wrap_if_pc", w_if_pc, 32'h0);
    chk("rst_wrap_if_instr", w_if_instr, 32'h0);

    // PC wrap-around on the second instance.
    @(negedge clk); w_req_ready = 1'b1; #1;
    chk("wrap_valid0", {31'd0, w_req_valid}, 32'd1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_addr2", w_addr, 32'h0000_0000);
    w_req_ready = 1'b0;

    // Streaming: one instruction per cycle from cycle 2.
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (k >= 2) begin
        chk("stream_if_valid", {31'd0, s_iv}, 32'd1);
        chk("stream_if_pc", s_pc, 32'(k - 2) * 32'd4);
      end
    end

    // Queue fills with decode stalled, then drains in order.
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'h0, tbl[k].rr, tbl[k].ir);
      chk("tbl_req_valid", {31'd0, s_rv}, {31'd0, tbl[k].exp_rv});
      if (tbl[k].exp_rv) chk("tbl_imem_addr", s_addr, tbl[k].exp_addr);
      chk("tbl_if_valid", {31'd0, s_iv}, {31'd0, tbl[k].exp_iv});
      if (tbl[k].exp_iv) chk("tbl_if_pc", s_pc, tbl[k].exp_pc);
    end

    // Redirect with three requests outstanding on a 3-cycle memory.
    do_reset(3);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b0);
    chk("redir_no_issue", {31'd0, s_rv}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir_req_valid", {31'd0, s_rv}, 32'd1);
    chk("redir_addr", s_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      if (s_iv) begin
        found = 1'b1;
        chk("redir_first_cycle", 32'(cyc - 1), 32'd8);
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    if (!found) chk("redir_timeout", 32'd0, 32'd1);

    // Redirect colliding with a response and a ready decode on a filled head.
    do_reset(1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    chk("collide_if_valid", {31'd0, s_iv}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("collide_req_valid", {31'd0, s_rv}, 32'd1);
    chk("collide_addr", s_addr, 32'h200);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Asynchronous reset mid-stream with filled entries.
    do_reset(1);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    rsp_valid = 1'b0;
    #1;
    chk("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_imem_addr", imem_addr, 32'h0);
    chk("midrst_req_valid", {31'd0, req_valid}, 32'd1);
    chk("midrst_if_pc", if_pc, 32'h0);

    // Random traffic at several memory latencies.
    for (int p = 0; p < 4; p++) begin
      do_reset(p + 1);
      for (int k = 0; k < 400; k++) begin
        rnd = $urandom;
        step(($urandom_range(0, 19) == 0), rnd & 32'hFFFF_FFFC,
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
